// File: rtl/alpha_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/gnt/rvalid port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode/EX side.
interface alpha_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/alpha_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited in-order imem reads, prefetch FIFO to decode.
// Word reaches id_valid one cycle after its rvalid; decode stall holds words, fetch stops when no credit.
module alpha_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input logic                clk,
  input logic                rst,
  alpha_fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic [OW-1:0] outst;
  logic [OW-1:0] drop;
  logic [OW-1:0] outst_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [31:0]   inst_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   tag_mem  [FIFO_DEPTH];
  logic          req;
  logic          fire;
  logic          rsp;
  logic          push;
  logic          pop;

  // Every outstanding word (including ones to be dropped) already owns a FIFO slot.
  always_comb begin
    credit_used = {1'b0, count} + (CW+1)'(outst);
    req         = (state == ST_RUN) && !bus.redirect &&
                  (outst < OW'(MAX_OUTST)) && (credit_used < (CW+1)'(FIFO_DEPTH));
    fire        = req && bus.imem_gnt;
    rsp         = bus.imem_rvalid && (outst != '0);
    push        = rsp && (drop == '0) && !bus.redirect;
    pop         = (count != '0) && bus.id_ready;
    outst_nxt   = outst + OW'(fire) - OW'(rsp);
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = (count != '0);
  assign bus.id_inst   = inst_mem[rd_ptr];
  assign bus.id_pc     = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        tag_mem[i]  <= '0;
      end
    end else begin
      state <= ST_RUN;
      outst <= outst_nxt;

      if (bus.redirect)
        fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (fire)
        fetch_pc <= fetch_pc + 32'd4;

      // Tag queue is not flushed: dropped responses still consume their tags in order.
      if (fire) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_wr + AW'(1);
      end
      if (rsp)
        tag_rd <= tag_rd + AW'(1);

      if (bus.redirect)
        drop <= outst_nxt;
      else if (rsp && (drop != '0))
        drop <= drop - OW'(1);

      if (push) begin
        inst_mem[wr_ptr] <= bus.imem_rdata;
        pc_mem[wr_ptr]   <= tag_mem[tag_rd];
      end

      if (bus.redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
